// File: rtl/systolic_skew_buf.sv
// Input skew/deskew buffer for the systolic array: per-lane delay lines with valid
// sideband, zero bubbles on idle cycles, and a drain counter with completion pulse.
module systolic_skew_buf #(
  parameter int N   = 8,
  parameter int R   = 8,
  parameter int C   = 8,
  parameter int DIR = 0
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic           Clr,
  input  logic           In_Dv,
  input  logic [R*N-1:0] A_in,
  input  logic [C*N-1:0] B_in,
  output logic [R*N-1:0] A_out,
  output logic [C*N-1:0] B_out,
  output logic [R-1:0]   A_vld,
  output logic [C-1:0]   B_vld,
  output logic           Busy,
  output logic           Drain_done
);

  localparam int L  = (R > C) ? R : C;
  localparam int CW = $clog2(L + 1);

  // Row lanes: lane k is a D-deep shift register of data and valid.
  for (genvar k = 0; k < R; k++) begin : g_a
    localparam int D = (DIR == 0) ? k + 1 : R - k;
    logic [D*N-1:0] dat_q, dat_d;
    logic [D-1:0]   vld_q, vld_d;
    logic [N-1:0]   lane_in;

    assign lane_in = (In_Dv && !Clr) ? A_in[k*N +: N] : '0;

    if (D == 1) begin : g_one
      always_comb begin
        dat_d = Clr ? '0 : lane_in;
        vld_d = In_Dv & ~Clr;
      end
    end else begin : g_many
      always_comb begin
        dat_d = Clr ? '0 : {dat_q[(D-1)*N-1:0], lane_in};
        vld_d = Clr ? '0 : {vld_q[D-2:0], In_Dv};
      end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        dat_q <= '0;
        vld_q <= '0;
      end else begin
        dat_q <= dat_d;
        vld_q <= vld_d;
      end
    end

    assign A_out[k*N +: N] = dat_q[(D-1)*N +: N];
    assign A_vld[k]        = vld_q[D-1];
  end

  // Column lanes mirror the row lanes with C in place of R.
  for (genvar k = 0; k < C; k++) begin : g_b
    localparam int D = (DIR == 0) ? k + 1 : C - k;
    logic [D*N-1:0] dat_q, dat_d;
    logic [D-1:0]   vld_q, vld_d;
    logic [N-1:0]   lane_in;

    assign lane_in = (In_Dv && !Clr) ? B_in[k*N +: N] : '0;

    if (D == 1) begin : g_one
      always_comb begin
        dat_d = Clr ? '0 : lane_in;
        vld_d = In_Dv & ~Clr;
      end
    end else begin : g_many
      always_comb begin
        dat_d = Clr ? '0 : {dat_q[(D-1)*N-1:0], lane_in};
        vld_d = Clr ? '0 : {vld_q[D-2:0], In_Dv};
      end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        dat_q <= '0;
        vld_q <= '0;
      end else begin
        dat_q <= dat_d;
        vld_q <= vld_d;
      end
    end

    assign B_out[k*N +: N] = dat_q[(D-1)*N +: N];
    assign B_vld[k]        = vld_q[D-1];
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // The counter spans the deepest lane, so it is nonzero exactly while a sample is in flight.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (Clr) begin
      cnt_d = '0;
    end else if (In_Dv) begin
      cnt_d = CW'(L);
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - CW'(1);
      done_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign Busy       = (cnt_q != '0);
  assign Drain_done = done_q;

endmodule

// File: tb/tb_systolic_skew_buf.sv
// Bench for systolic_skew_buf: a skew instance (R=3,C=5) and a deskew instance (R=4,C=4)
// share control and are checked every cycle against a sample-history reference model.
module tb_systolic_skew_buf;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Clr = 1'b0;
  logic        In_Dv = 1'b0;
  logic [23:0] A_in0 = '0;
  logic [39:0] B_in0 = '0;
  logic [31:0] A_in1 = '0;
  logic [31:0] B_in1 = '0;

  logic [23:0] A_out0;
  logic [2:0]  A_vld0;
  logic [39:0] B_out0;
  logic [4:0]  B_vld0;
  logic        Busy0, Drain_done0;
  logic [31:0] A_out1, B_out1;
  logic [3:0]  A_vld1, B_vld1;
  logic        Busy1, Drain_done1;

  logic [73:0] obs0, obs1, exp0, exp1;

  int vectors = 0;
  int miscompares = 0;
  int ecount = 0;
  int cb = 0;
  bit          hv [0:1023];
  logic [63:0] hd [4][0:1023];

  always #5 Clk = ~Clk;

  systolic_skew_buf #(.N(8), .R(3), .C(5), .DIR(0)) dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .Clr(Clr), .In_Dv(In_Dv),
    .A_in(A_in0), .B_in(B_in0), .A_out(A_out0), .B_out(B_out0),
    .A_vld(A_vld0), .B_vld(B_vld0), .Busy(Busy0), .Drain_done(Drain_done0)
  );

  systolic_skew_buf #(.N(8), .R(4), .C(4), .DIR(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .Clr(Clr), .In_Dv(In_Dv),
    .A_in(A_in1), .B_in(B_in1), .A_out(A_out1), .B_out(B_out1),
    .A_vld(A_vld1), .B_vld(B_vld1), .Busy(Busy1), .Drain_done(Drain_done1)
  );

  assign obs0 = {A_out0, A_vld0, B_out0, B_vld0, Busy0, Drain_done0};
  assign obs1 = {A_out1, A_vld1, B_out1, B_vld1, Busy1, Drain_done1};

  // A sample captured at edge e on a lane of depth D is visible after edge e+D-1,
  // unless a clear or reset (barrier cb) came after it.
  function automatic void lane_exp(input int p, input int lanes, input int dir, input int k,
                                   input int t, output logic [7:0] d, output logic v);
    int dep;
    int e;
    dep = (dir == 0) ? k + 1 : lanes - k;
    e   = t - dep + 1;
    if (e >= 0 && e >= cb && hv[e]) begin
      d = hd[p][e][k*8 +: 8];
      v = 1'b1;
    end else begin
      d = 8'h00;
      v = 1'b0;
    end
  endfunction

  function automatic bit busy_at(input int t, input int l);
    for (int i = 0; i < l; i++) begin
      if (t - i >= 0 && t - i >= cb && hv[t - i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic predict(input int t, input bit clr);
    logic [7:0]  d;
    logic        v;
    logic [23:0] a0;
    logic [2:0]  av0;
    logic [39:0] b0;
    logic [4:0]  bv0;
    logic [31:0] a1, b1;
    logic [3:0]  av1, bv1;
    for (int k = 0; k < 3; k++) begin lane_exp(0, 3, 0, k, t, d, v); a0[k*8 +: 8] = d; av0[k] = v; end
    for (int k = 0; k < 5; k++) begin lane_exp(1, 5, 0, k, t, d, v); b0[k*8 +: 8] = d; bv0[k] = v; end
    for (int k = 0; k < 4; k++) begin lane_exp(2, 4, 1, k, t, d, v); a1[k*8 +: 8] = d; av1[k] = v; end
    for (int k = 0; k < 4; k++) begin lane_exp(3, 4, 1, k, t, d, v); b1[k*8 +: 8] = d; bv1[k] = v; end
    exp0 = {a0, av0, b0, bv0, busy_at(t, 5), busy_at(t - 1, 5) && !busy_at(t, 5) && !clr};
    exp1 = {a1, av1, b1, bv1, busy_at(t, 4), busy_at(t - 1, 4) && !busy_at(t, 4) && !clr};
  endtask

  // Drive one cycle, record what was captured at the edge, and leave time at edge+1.
  task automatic cycle(input bit dv, input bit clr, input bit fix);
    In_Dv = dv;
    Clr   = clr;
    A_in0 = 24'($urandom);
    B_in0 = {8'($urandom), 32'($urandom)};
    A_in1 = fix ? 32'h44332211 : 32'($urandom);
    B_in1 = 32'($urandom);
    @(posedge Clk);
    hv[ecount]    = dv && !clr;
    hd[0][ecount] = 64'(A_in0);
    hd[1][ecount] = 64'(B_in0);
    hd[2][ecount] = 64'(A_in1);
    hd[3][ecount] = 64'(B_in1);
    if (clr) cb = ecount + 1;
    predict(ecount, clr);
    ecount++;
    #1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    if (obs0 !== 74'b0) begin
      miscompares++;
      $display("[TB] FAIL reset dut0 got %h want 0", obs0);
    end
    vectors++;
    if (obs1 !== 74'b0) begin
      miscompares++;
      $display("[TB] FAIL reset dut1 got %h want 0", obs1);
    end
    vectors++;
    Rst_n = 1'b1;
    cb = ecount;
  endtask

  task automatic test_single_pulse();
    int done0_n = 0, done1_n = 0, done0_at = -1, done1_at = -1, busy1_n = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(i == 0, 1'b0, 1'b1);
      if (obs0 !== exp0) begin
        miscompares++;
        $display("[TB] FAIL pulse dut0 edge %0d got %h want %h", i, obs0, exp0);
      end
      vectors++;
      if (obs1 !== exp1) begin
        miscompares++;
        $display("[TB] FAIL pulse dut1 edge %0d got %h want %h", i, obs1, exp1);
      end
      vectors++;
      if (Drain_done0) begin done0_n++; done0_at = i; end
      if (Drain_done1) begin done1_n++; done1_at = i; end
      if (Busy1) busy1_n++;
    end
    if (done0_n !== 1 || done0_at !== 5) begin
      miscompares++;
      $display("[TB] FAIL pulse_done0 got %0d pulses at %0d want 1 at 5", done0_n, done0_at);
    end
    vectors++;
    if (done1_n !== 1 || done1_at !== 4 || busy1_n !== 4) begin
      miscompares++;
      $display("[TB] FAIL pulse_done1 got %0d pulses at %0d busy %0d want 1 at 4 busy 4",
               done1_n, done1_at, busy1_n);
    end
    vectors++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 14; i++) begin
      cycle(i < 6, 1'b0, 1'b0);
      if (obs0 !== exp0) begin
        miscompares++;
        $display("[TB] FAIL burst dut0 edge %0d got %h want %h", i, obs0, exp0);
      end
      vectors++;
      if (obs1 !== exp1) begin
        miscompares++;
        $display("[TB] FAIL burst dut1 edge %0d got %h want %h", i, obs1, exp1);
      end
      vectors++;
    end
  endtask

  task automatic test_bubbles();
    for (int i = 0; i < 14; i++) begin
      cycle(i < 6 && (i % 2 == 0), 1'b0, 1'b0);
      if (obs0 !== exp0) begin
        miscompares++;
        $display("[TB] FAIL bubble dut0 edge %0d got %h want %h", i, obs0, exp0);
      end
      vectors++;
      if (obs1 !== exp1) begin
        miscompares++;
        $display("[TB] FAIL bubble dut1 edge %0d got %h want %h", i, obs1, exp1);
      end
      vectors++;
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 10; i++) begin
      cycle(i < 3, i == 2, 1'b0);
      if (obs0 !== exp0) begin
        miscompares++;
        $display("[TB] FAIL clear dut0 edge %0d got %h want %h", i, obs0, exp0);
      end
      vectors++;
      if (obs1 !== exp1) begin
        miscompares++;
        $display("[TB] FAIL clear dut1 edge %0d got %h want %h", i, obs1, exp1);
      end
      vectors++;
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    #2;
    Rst_n = 1'b0;
    In_Dv = 1'b0;
    #1;
    if (obs0 !== 74'b0 || obs1 !== 74'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset got %h / %h want 0", obs0, obs1);
    end
    vectors++;
    #2;
    Rst_n = 1'b1;
    cb = ecount;
    for (int i = 0; i < 8; i++) begin
      cycle(i == 0, 1'b0, 1'b1);
      if (obs0 !== exp0) begin
        miscompares++;
        $display("[TB] FAIL post_reset dut0 edge %0d got %h want %h", i, obs0, exp0);
      end
      vectors++;
      if (obs1 !== exp1) begin
        miscompares++;
        $display("[TB] FAIL post_reset dut1 edge %0d got %h want %h", i, obs1, exp1);
      end
      vectors++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 120; i++) begin
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, 1'b0);
      if (obs0 !== exp0) begin
        miscompares++;
        $display("[TB] FAIL random dut0 edge %0d got %h want %h", i, obs0, exp0);
      end
      vectors++;
      if (obs1 !== exp1) begin
        miscompares++;
        $display("[TB] FAIL random dut1 edge %0d got %h want %h", i, obs1, exp1);
      end
      vectors++;
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_back_to_back();
    test_bubbles();
    test_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/systolic_skew_buf.md
Name: systolic_skew_buf

Overview:
- Input skew buffer for the systolic matrix-multiply array.
- Takes one row-operand vector (R lanes) and one column-operand vector (C lanes) per cycle and delays lane k so operands arrive at array edge PEs on the correct diagonal wavefront.
- Generalises the fixed square skew stage: independent row/column lane counts, per-lane valid sideband, zero-bubble insertion on every lane, selectable skew/deskew direction (deskew reuses the block on the array output side), and drain tracking with a completion pulse.

Parameters:
- N, 8, data width per lane in bits.
- R, 8, row-operand lane count (R >= 1).
- C, 8, column-operand lane count (C >= 1).
- DIR, 0, 0 = skew (lane k delayed k extra cycles); 1 = deskew (lane k delayed (lanes-1-k) extra cycles).

Ports:
- Clk  input  1  clock, all state updates on rising edge.
- Rst_n  input  1  reset, asynchronous, active-low.
- Clr  input  1  synchronous clear of all pipeline state.
- In_Dv  input  1  input vectors valid this cycle.
- A_in  input  R*N  row operands; lane k at bits [(k+1)*N-1 : k*N].
- B_in  input  C*N  column operands; same lane packing.
- A_out  output  R*N  skewed row operands.
- B_out  output  C*N  skewed column operands.
- A_vld  output  R  per-lane valid for A_out.
- B_vld  output  C  per-lane valid for B_out.
- Busy  output  1  high while any valid sample is in flight.
- Drain_done  output  1  one-cycle pulse when the pipeline empties.

Behaviour:
- Reset (Rst_n=0, async): all data stages, valid stages and the drain counter go to 0. A_out=0, B_out=0, A_vld=0, B_vld=0, Busy=0, Drain_done=0.
- Capture:
  - Every rising edge, each lane's first stage loads the input lane if In_Dv=1.
  - If In_Dv=0, it loads data 0 and valid 0. Zero bubbles occur on all lanes, not only lane 0.
- Delay, with lane depth DA(k) for lane k of A:
  - DIR=0: DA(k) = k+1 registers.
  - DIR=1: DA(k) = R-k registers.
  - B is the same with C in place of R.
  - A sample captured at edge e appears on lane k outputs after edge e+DA(k)-1. Lane 0 with DIR=0 therefore has one-cycle latency.
- Valid travels in lockstep with data. Outputs are registered only, with no combinational path from inputs.
- Drain counter:
  - Width clog2(L+1), where L = max(R,C).
  - In_Dv=1: load L.
  - Otherwise, if nonzero, decrement.
  - Busy = (cnt != 0). Busy is exactly the OR of all internal valid bits.
- Drain_done:
  - Registered pulse, high for the one cycle after the edge where cnt goes 1 -> 0.
  - Not asserted if In_Dv=1 on that edge, because the counter reloads instead.
- Back-to-back In_Dv: every cycle is a new wavefront; no stall, no backpressure. Throughput is one vector per cycle.
- Clr=1 at an edge:
  - Zeros all stages, valids and the counter. Drain_done=0 next cycle.
  - Clr has priority over a simultaneous In_Dv; that input is dropped.
- Reset mid-stream: in-flight data is discarded immediately (async). The first valid after release behaves as from idle.
- R=1 or C=1: a single one-register lane is legal; the counter still uses L.
- Arithmetic: data passes through untouched, with no sign extension or width change.

Test Plan:
- R=C=4, N=8, DIR=0; single In_Dv pulse with A_in lanes 0x11,0x22,0x33,0x44 at edge 0 -> A lane k shows its value only after edge k, with A_vld[k] high for exactly one cycle. Busy is high 4 cycles. Drain_done pulses once, in the cycle after edge 4.
- R=3, C=5, DIR=0; In_Dv held for 6 consecutive cycles with incrementing data -> each lane outputs a contiguous 6-sample stream, offset k cycles. Busy stays high until 5 cycles after the last In_Dv, then Drain_done pulses once.
- R=C=4, DIR=1; one pulse -> lane 3 outputs after edge 0 and lane 0 after edge 3. Feeding skew output into a deskew instance realigns all lanes to one cycle, total latency 5.
- Alternating In_Dv 1,0,1,0 with nonzero data during the 0 cycles -> the 0 cycles produce data 0 and vld 0 on every lane. Drain_done appears only after the final sample.
- Clr asserted 2 cycles into a burst, together with In_Dv=1 -> all outputs and Busy are 0 the next cycle, with no Drain_done pulse and no later valid output.
- Rst_n dropped asynchronously mid-burst, between clock edges -> outputs go to 0 immediately. After release, a fresh pulse gives the latencies of scenario 1.
